// File: rtl/shift_pkg.sv
// Shared defaults, op encodings and the op-field type for the execute-stage shift unit.
package shift_pkg;

    localparam int DEF_DW = 32;
    localparam int DEF_SW = 5;
    localparam int DEF_RW = 5;

    typedef logic [2:0] op_t;

    localparam op_t OP_ROR  = 3'b000;
    localparam op_t OP_ROL  = 3'b001;
    localparam op_t OP_SRL  = 3'b010;
    localparam op_t OP_SLL  = 3'b011;
    localparam op_t OP_SRA  = 3'b100;
    localparam op_t OP_PASS = 3'b101;  // 101..111 all decode as PASS

endpackage

// File: rtl/shift_exec_stage_rotr_core.sv
// Combinational DW-bit rotate-right by a SW-bit amount.
// Log-depth barrel: stage i rotates by 2**i when bit i of the amount is set.
module rotr_core #(
    parameter int DW = 32,
    parameter int SW = 5
) (
    input  logic [DW-1:0] a_i,
    input  logic [SW-1:0] k_i,
    output logic [DW-1:0] r_o
);

    logic [DW-1:0] acc;

    always_comb begin
        acc = a_i;
        for (int i = 0; i < SW; i++) begin
            if (k_i[i]) begin
                acc = (acc >> (1 << i)) | (acc << (DW - (1 << i)));
            end
        end
    end

    assign r_o = acc;

endmodule

// File: rtl/shift_exec_stage.sv
// Two-stage valid/ready execute-stage shift/rotate unit with flush.
// S1 holds the decoded operands; the rotate core, masking and carry sit between S1 and S2.
module shift_exec_stage
    import shift_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int SW = DEF_SW,
    parameter int RW = DEF_RW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  op_t           in_op,
    input  logic [DW-1:0] in_a,
    input  logic [SW-1:0] in_sh,
    input  logic [RW-1:0] in_rd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_f,
    output logic [RW-1:0] out_rd,
    output logic          out_z,
    output logic          out_n,
    output logic          out_c,
    output logic          busy
);

    logic          s1_valid_q, s1_valid_d;
    op_t           s1_op_q,    s1_op_d;
    logic [DW-1:0] s1_a_q,     s1_a_d;
    logic [SW-1:0] s1_sh_q,    s1_sh_d;
    logic [RW-1:0] s1_rd_q,    s1_rd_d;

    logic          s2_valid_q, s2_valid_d;
    logic [DW-1:0] s2_f_q,     s2_f_d;
    logic [RW-1:0] s2_rd_q,    s2_rd_d;
    logic          s2_c_q,     s2_c_d;

    logic s1_adv, s2_adv;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    // ---------------- execute logic between S1 and S2 ----------------
    logic [SW:0]   neg_sh_w;
    logic [SW-1:0] neg_sh;
    logic [SW-1:0] sh_m1;
    logic [SW-1:0] rot_k;
    logic [DW-1:0] rot_r;
    logic [DW-1:0] ones;
    logic [DW-1:0] mask_r;
    logic [DW-1:0] mask_l;
    logic [DW-1:0] f_calc;
    logic          c_calc;

    // Left shifts/rotates reuse the right rotator with amount (DW - SH) mod DW.
    assign neg_sh_w = (SW+1)'(DW) - {1'b0, s1_sh_q};
    assign neg_sh   = neg_sh_w[SW-1:0];
    assign sh_m1    = s1_sh_q - SW'(1);
    assign rot_k    = (s1_op_q == OP_ROL || s1_op_q == OP_SLL) ? neg_sh : s1_sh_q;
    assign ones     = '1;
    assign mask_r   = ones >> s1_sh_q;
    assign mask_l   = ones << s1_sh_q;

    rotr_core #(
        .DW (DW),
        .SW (SW)
    ) u_rotr (
        .a_i (s1_a_q),
        .k_i (rot_k),
        .r_o (rot_r)
    );

    always_comb begin
        f_calc = s1_a_q;
        c_calc = 1'b0;
        case (s1_op_q)
            OP_ROR: begin
                f_calc = rot_r;
                c_calc = rot_r[DW-1];
            end
            OP_ROL: begin
                f_calc = rot_r;
                c_calc = rot_r[0];
            end
            OP_SRL: begin
                f_calc = rot_r & mask_r;
                c_calc = s1_a_q[sh_m1];
            end
            OP_SLL: begin
                f_calc = rot_r & mask_l;
                c_calc = s1_a_q[neg_sh];
            end
            OP_SRA: begin
                f_calc = (rot_r & mask_r) | (s1_a_q[DW-1] ? ~mask_r : '0);
                c_calc = s1_a_q[sh_m1];
            end
            default: begin
                f_calc = s1_a_q;
                c_calc = 1'b0;
            end
        endcase
        // A zero shift never moves a bit out, whatever the op.
        if (s1_sh_q == '0) begin
            c_calc = 1'b0;
        end
    end

    // ---------------- next-state ----------------
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_a_d     = s1_a_q;
        s1_sh_d    = s1_sh_q;
        s1_rd_d    = s1_rd_q;
        s2_valid_d = s2_valid_q;
        s2_f_d     = s2_f_q;
        s2_rd_d    = s2_rd_q;
        s2_c_d     = s2_c_q;

        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_op_d = in_op;
                s1_a_d  = in_a;
                s1_sh_d = in_sh;
                s1_rd_d = in_rd;
            end
        end
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_f_d  = f_calc;
                s2_rd_d = s1_rd_q;
                s2_c_d  = c_calc;
            end
        end
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= OP_ROR;
            s1_a_q     <= '0;
            s1_sh_q    <= '0;
            s1_rd_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_f_q     <= '0;
            s2_rd_q    <= '0;
            s2_c_q     <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_a_q     <= s1_a_d;
            s1_sh_q    <= s1_sh_d;
            s1_rd_q    <= s1_rd_d;
            s2_valid_q <= s2_valid_d;
            s2_f_q     <= s2_f_d;
            s2_rd_q    <= s2_rd_d;
            s2_c_q     <= s2_c_d;
        end
    end

    // Z/N come from the registered result; gating with valid keeps them low out of reset.
    assign out_valid = s2_valid_q;
    assign out_f     = s2_f_q;
    assign out_rd    = s2_rd_q;
    assign out_c     = s2_c_q;
    assign out_z     = s2_valid_q && (s2_f_q == '0);
    assign out_n     = s2_valid_q && s2_f_q[DW-1];
    assign busy      = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Directed self-checking bench for shift_exec_stage: op results, boundaries,
// backpressure, flush and asynchronous reset.
module tb_shift_exec_stage;
    import shift_pkg::*;

    localparam int DW = 32;
    localparam int SW = 5;
    localparam int RW = 5;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    op_t           in_op;
    logic [DW-1:0] in_a;
    logic [SW-1:0] in_sh;
    logic [RW-1:0] in_rd;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_f;
    logic [RW-1:0] out_rd;
    logic          out_z;
    logic          out_n;
    logic          out_c;
    logic          busy;

    shift_exec_stage #(
        .DW (DW),
        .SW (SW),
        .RW (RW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_sh     (in_sh),
        .in_rd     (in_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_f     (out_f),
        .out_rd    (out_rd),
        .out_z     (out_z),
        .out_n     (out_n),
        .out_c     (out_c),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input op_t op, input logic [31:0] a,
                          input logic [4:0] sh, input logic [4:0] rd,
                          input logic [31:0] ef, input logic ec, input logic ez, input logic en);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_op     = op;
        in_a      = a;
        in_sh     = sh;
        in_rd     = rd;
        #1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_lat1_valid"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_f"}, out_f, ef);
        check({tag, "_rd"}, 32'(out_rd), 32'(rd));
        check({tag, "_c"}, 32'(out_c), 32'(ec));
        check({tag, "_z"}, 32'(out_z), 32'(ez));
        check({tag, "_n"}, 32'(out_n), 32'(en));
        $display("txn %s op=%0d a=%h sh=%0d -> f=%h rd=%0d c=%0b z=%0b n=%0b",
                 tag, op, a, sh, out_f, out_rd, out_c, out_z, out_n);
    endtask

    // Stream table: hand-computed results for A/op/SH below.
    op_t         s_op [5];
    logic [31:0] s_a  [5];
    logic [4:0]  s_sh [5];
    logic [31:0] s_f  [5];

    initial begin
        s_op[0] = OP_ROR; s_a[0] = 32'h8000_0001; s_sh[0] = 5'd4;  s_f[0] = 32'h1800_0000;
        s_op[1] = OP_SRA; s_a[1] = 32'h8000_0001; s_sh[1] = 5'd4;  s_f[1] = 32'hF800_0000;
        s_op[2] = OP_SLL; s_a[2] = 32'h8000_0001; s_sh[2] = 5'd1;  s_f[2] = 32'h0000_0002;
        s_op[3] = OP_SRL; s_a[3] = 32'h8000_0000; s_sh[3] = 5'd31; s_f[3] = 32'h0000_0001;
        s_op[4] = OP_ROL; s_a[4] = 32'h8000_0001; s_sh[4] = 5'd4;  s_f[4] = 32'h0000_0018;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int in_idx;
        int out_idx;
        bit held;
        bit saw_stall;
        logic [31:0] held_f;
        logic [4:0]  held_rd;

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = OP_ROR;
        in_a      = '0;
        in_sh     = '0;
        in_rd     = '0;
        out_ready = 1'b1;

        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_f", out_f, 32'd0);
        check("rst_flags", {29'd0, out_z, out_n, out_c}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // ---------------- directed ops ----------------
        run_op("ror4",   OP_ROR,  32'h8000_0001, 5'd4,  5'd1, 32'h1800_0000, 1'b0, 1'b0, 1'b0);
        run_op("sra4",   OP_SRA,  32'h8000_0001, 5'd4,  5'd2, 32'hF800_0000, 1'b0, 1'b0, 1'b1);
        run_op("sll1",   OP_SLL,  32'h8000_0001, 5'd1,  5'd3, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
        run_op("rol0",   OP_ROL,  32'h0000_00FF, 5'd0,  5'd4, 32'h0000_00FF, 1'b0, 1'b0, 1'b0);
        run_op("srl31a", OP_SRL,  32'h8000_0000, 5'd31, 5'd5, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        run_op("srl31b", OP_SRL,  32'h7FFF_FFFF, 5'd31, 5'd6, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
        run_op("rol1",   OP_ROL,  32'h8000_0001, 5'd1,  5'd7, 32'h0000_0003, 1'b1, 1'b0, 1'b0);
        run_op("sll4",   OP_SLL,  32'h8000_0001, 5'd4,  5'd8, 32'h0000_0010, 1'b0, 1'b0, 1'b0);
        run_op("ror1",   OP_ROR,  32'h8000_0001, 5'd1,  5'd9, 32'hC000_0000, 1'b1, 1'b0, 1'b1);
        run_op("sra0",   OP_SRA,  32'h8000_0001, 5'd0,  5'd10, 32'h8000_0001, 1'b0, 1'b0, 1'b1);
        run_op("pass",   3'b110,  32'h1234_5678, 5'd7,  5'd11, 32'h1234_5678, 1'b0, 1'b0, 1'b0);

        // ---------------- backpressure stream ----------------
        in_idx    = 0;
        out_idx   = 0;
        held      = 1'b0;
        saw_stall = 1'b0;
        held_f    = '0;
        held_rd   = '0;
        for (int c = 0; c < 40 && out_idx < 5; c++) begin
            @(negedge clk);
            out_ready = !(c >= 2 && c < 5);
            in_valid  = (in_idx < 5);
            if (in_idx < 5) begin
                in_op = s_op[in_idx];
                in_a  = s_a[in_idx];
                in_sh = s_sh[in_idx];
                in_rd = 5'(20 + in_idx);
            end
            #1;
            if (held && out_valid) begin
                check("bp_hold_f", out_f, held_f);
                check("bp_hold_rd", 32'(out_rd), 32'(held_rd));
            end
            held = 1'b0;
            if (c == 2) check("bp_full_in_ready", 32'(in_ready), 32'd0);
            if (c == 5) check("bp_rate_restored", 32'(in_ready), 32'd1);
            if (!in_ready) saw_stall = 1'b1;
            if (out_valid && out_ready) begin
                if (out_idx < 5) begin
                    check("bp_f", out_f, s_f[out_idx]);
                    check("bp_rd", 32'(out_rd), 32'(20 + out_idx));
                end else begin
                    check("bp_extra_result", 32'd1, 32'd0);
                end
                $display("txn stream%0d f=%h rd=%0d", out_idx, out_f, out_rd);
                out_idx++;
            end else if (out_valid) begin
                held    = 1'b1;
                held_f  = out_f;
                held_rd = out_rd;
            end
            if (in_valid && in_ready) in_idx++;
        end
        in_valid = 1'b0;
        check("bp_out_count", 32'(out_idx), 32'd5);
        check("bp_in_count", 32'(in_idx), 32'd5);
        check("bp_stall_seen", 32'(saw_stall), 32'd1);
        repeat (3) begin
            @(negedge clk);
            check("bp_no_dup", 32'(out_valid), 32'd0);
        end

        // ---------------- flush ----------------
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = OP_PASS;
        in_a      = 32'hAAAA_0001;
        in_sh     = 5'd0;
        in_rd     = 5'd12;
        @(negedge clk);
        in_a  = 32'hAAAA_0002;
        in_rd = 5'd13;
        @(negedge clk);
        check("fl_pre_busy", 32'(busy), 32'd1);
        check("fl_pre_valid", 32'(out_valid), 32'd1);
        flush     = 1'b1;
        out_ready = 1'b1;
        in_a      = 32'hDEAD_0003;
        in_rd     = 5'd14;
        #1;
        check("fl_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        check("fl_out_valid", 32'(out_valid), 32'd0);
        check("fl_busy", 32'(busy), 32'd0);
        $display("txn flush out_valid=%0b busy=%0b", out_valid, busy);
        flush    = 1'b0;
        in_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("fl_dropped", 32'(out_valid), 32'd0);
        end
        run_op("fl_after", OP_SRL, 32'hF000_0000, 5'd4, 5'd15, 32'h0F00_0000, 1'b0, 1'b0, 1'b0);

        // ---------------- asynchronous reset mid-stream ----------------
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = OP_SLL;
        in_a      = 32'hC000_0001;
        in_sh     = 5'd1;
        in_rd     = 5'd16;
        @(negedge clk);
        in_op = OP_ROR;
        in_rd = 5'd17;
        @(negedge clk);
        in_valid = 1'b0;
        check("ar_pre_valid", 32'(out_valid), 32'd1);
        check("ar_pre_f", out_f, 32'h8000_0002);
        check("ar_pre_c", 32'(out_c), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_out_valid", 32'(out_valid), 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_out_f", out_f, 32'd0);
        check("ar_out_rd", 32'(out_rd), 32'd0);
        check("ar_flags", {29'd0, out_z, out_n, out_c}, 32'd0);
        $display("txn async_reset out_valid=%0b busy=%0b f=%h", out_valid, busy, out_f);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("ar_after", OP_SRA, 32'h8000_0000, 5'd31, 5'd18, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
